cv32e40p_wb_port_arbiter: RTL and testbench

//  Shares the single EX-stage register-file write port (ALU/fwd port) between the in-order

---
 rtl/cv32e40p_pkg.sv | 21 ++
 rtl/cv32e40p_rr_arbiter.sv | 73 +++++++
 rtl/cv32e40p_wb_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cv32e40p_wb_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared constants and types for the write-back port arbiter.
//   WB_ARB_MAX_WAIT_DEFAULT : default refusal limit before a low-priority
//                             requester overrides the in-order result
//   WB_ARB_ADDR_W/DATA_W    : default register address / data widths
//   wb_req_t                : one write-back request {waddr, wdata} at the
//                             default widths
// -----------------------------------------------------------------------------
package cv32e40p_pkg;

    localparam int unsigned WB_ARB_MAX_WAIT_DEFAULT = 4;
    localparam int unsigned WB_ARB_ADDR_W           = 6;
    localparam int unsigned WB_ARB_DATA_W           = 32;

    typedef struct packed {
        logic [WB_ARB_ADDR_W-1:0] waddr;
        logic [WB_ARB_DATA_W-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/cv32e40p_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40p_rr_arbiter
// Round-robin pick over WIDTH candidates. The caller supplies the candidate
// mask (starved set or plain valid set); the first set bit at or after the
// internal pointer wins, wrapping from WIDTH-1 back to 0. Whenever a grant is
// issued the pointer moves to the slot after the winner.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   i_mask     : candidate set
//   o_gnt      : one-hot grant (zero when i_mask is zero)
// -----------------------------------------------------------------------------
module cv32e40p_rr_arbiter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_gnt
);

    localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_hi_found;
    logic             w_lo_found;
    int               w_hi_idx;
    int               w_lo_idx;
    int               w_sel_idx;

    // Descending scan: the last hit is the lowest index. "hi" only considers
    // slots at/after the pointer; "lo" is the wrap-around fallback.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = 0;
        w_lo_idx   = 0;
        for (int j = WIDTH - 1; j >= 0; j--) begin
            if (i_mask[j]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = j;
                if (j >= int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = j;
                end
            end
        end
        w_sel_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        o_gnt = '0;
        for (int j = 0; j < WIDTH; j++) begin
            o_gnt[j] = w_lo_found && (w_sel_idx == j);
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_lo_found) begin
            w_ptr_nxt = (w_sel_idx == int'(WIDTH) - 1) ? '0 : PTR_W'(w_sel_idx + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/cv32e40p_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40p_wb_port_arbiter
// Shares the EX-stage register-file write port between the in-order result
// (requester 0, fixed priority) and out-of-order producers (requesters
// 1..NUM_REQ-1, round-robin). A low-priority requester refused MAX_WAIT times
// in a row becomes "starved" and pre-empts requester 0. The write port is
// registered (one cycle after the grant).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_valid_i   : per-requester result pending
//   req_waddr_i   : per-requester destination register (packed, ADDR_W each)
//   req_wdata_i   : per-requester result data (packed, DATA_W each)
//   req_ready_o   : one-hot combinational grant
//   stall_o       : requester 0 valid but refused
//   we_o/waddr_o/wdata_o : registered write port
//   contention_o  : registered, two or more requesters were valid
//   perf_cnt_o    : saturating contention-cycle counter
// Configuration macro: CV32E40P_WB_ARB_PERF_EN enables perf_cnt_o; when it is
// undefined perf_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module cv32e40p_wb_port_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned MAX_WAIT = WB_ARB_MAX_WAIT_DEFAULT,
    parameter int unsigned ADDR_W   = WB_ARB_ADDR_W,
    parameter int unsigned DATA_W   = WB_ARB_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_waddr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      stall_o,
    output logic                      we_o,
    output logic [ADDR_W-1:0]         waddr_o,
    output logic [DATA_W-1:0]         wdata_o,
    output logic                      contention_o,
    output logic [31:0]               perf_cnt_o
);

    if (NUM_REQ < 2 || MAX_WAIT < 1) begin : g_param_check
        $error("cv32e40p_wb_port_arbiter: NUM_REQ must be >= 2 and MAX_WAIT >= 1");
    end

    localparam int unsigned NUM_LO = NUM_REQ - 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    // Low-priority bookkeeping is indexed j = requester - 1.
    logic [WAIT_W-1:0] r_wait_cnt [NUM_LO];
    logic [NUM_LO-1:0] w_starved;
    logic [NUM_LO-1:0] w_rr_mask;
    logic [NUM_LO-1:0] w_rr_gnt;
    logic [NUM_REQ-1:0] w_ready;
    logic              w_grant_any;
    logic              w_multi;
    logic [ADDR_W-1:0] w_sel_waddr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_contention;

    always_comb begin
        w_starved = '0;
        for (int j = 0; j < int'(NUM_LO); j++) begin
            w_starved[j] = req_valid_i[j+1] && (r_wait_cnt[j] == WAIT_W'(MAX_WAIT));
        end
    end

    // Starved requesters outrank requester 0; otherwise requester 0 blocks the
    // round-robin entirely so the pointer only moves on real low-priority grants.
    always_comb begin
        if (|w_starved) begin
            w_rr_mask = w_starved;
        end else if (req_valid_i[0]) begin
            w_rr_mask = '0;
        end else begin
            w_rr_mask = req_valid_i[NUM_REQ-1:1];
        end
    end

    cv32e40p_rr_arbiter #(
        .WIDTH (NUM_LO)
    ) u_rr_arbiter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_mask (w_rr_mask),
        .o_gnt  (w_rr_gnt)
    );

    assign w_ready     = {w_rr_gnt, req_valid_i[0] & ~(|w_starved)};
    assign w_grant_any = |w_ready;
    assign w_multi     = ($countones(req_valid_i) >= 2);

    assign req_ready_o = w_ready;
    assign stall_o     = req_valid_i[0] & ~w_ready[0];

    always_comb begin
        w_sel_waddr = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_ready[i]) begin
                w_sel_waddr = req_waddr_i[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Refusal counters: count consecutive refused cycles, saturate at MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(NUM_LO); j++) begin
                r_wait_cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(NUM_LO); j++) begin
                if (!req_valid_i[j+1] || w_ready[j+1]) begin
                    r_wait_cnt[j] <= '0;
                end else if (r_wait_cnt[j] != WAIT_W'(MAX_WAIT)) begin
                    r_wait_cnt[j] <= r_wait_cnt[j] + 1'b1;
                end
            end
        end
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_contention <= 1'b0;
        end else begin
            r_we         <= w_grant_any;
            r_contention <= w_multi;
            if (w_grant_any) begin
                r_waddr <= w_sel_waddr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    assign we_o         = r_we;
    assign waddr_o      = r_waddr;
    assign wdata_o      = r_wdata;
    assign contention_o = r_contention;

`ifdef CV32E40P_WB_ARB_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cnt <= '0;
        end else if (w_multi && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_cnt_o = r_perf_cnt;
`else
    assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_wb_port_arbiter.sv
module tb_cv32e40p_wb_port_arbiter;
    import cv32e40p_pkg::*;

    localparam int N  = 3;
    localparam int MW = 4;
    localparam int AW = 6;
    localparam int DW = 32;
`ifdef CV32E40P_WB_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_waddr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic              stall;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              contention;
    logic [31:0]       perf_cnt;

    always #5 clk = ~clk;

    cv32e40p_wb_port_arbiter #(
        .NUM_REQ (N),
        .MAX_WAIT(MW),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_waddr_i (req_waddr),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready),
        .stall_o     (stall),
        .we_o        (we),
        .waddr_o     (waddr),
        .wdata_o     (wdata),
        .contention_o(contention),
        .perf_cnt_o  (perf_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues filled at grant time, drained by the monitor.
    wb_req_t     exp_wr_q[$];
    bit          exp_cont_q[$];
    int unsigned m_perf;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_data;
    bit          in_reset = 1'b1;

    // Reference model state (spec-level: pointer as requester number, counters as ints).
    int          m_ptr;
    int          m_wait[N];
    bit          cur_v[N];
    logic [AW-1:0] cur_addr[N];
    logic [DW-1:0] cur_data[N];
    bit          granted[N];
    int          prob[N];
    int          rec_q[$];
    bit          rec_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = cur_v[i];
            req_waddr[i*AW +: AW]   = cur_addr[i];
            req_wdata[i*DW +: DW]   = cur_data[i];
        end
    endtask

    task automatic model_reset();
        m_ptr = 1;
        m_perf = 0;
        m_last_addr = '0;
        m_last_data = '0;
        exp_wr_q.delete();
        exp_cont_q.delete();
        for (int i = 0; i < N; i++) begin
            m_wait[i]   = 0;
            cur_v[i]    = 1'b0;
            granted[i]  = 1'b0;
            cur_addr[i] = '0;
            cur_data[i] = '0;
        end
    endtask

    // Called at posedge+1: retire transferred requests, maybe present new ones.
    task automatic begin_cycle();
        for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
                cur_v[i]   = 1'b0;
                granted[i] = 1'b0;
            end
            if (!cur_v[i] && ($urandom_range(99) < prob[i])) begin
                cur_v[i]    = 1'b1;
                cur_addr[i] = AW'($urandom);
                cur_data[i] = $urandom;
            end
        end
        drive_bus();
    endtask

    // Called at negedge: decide the grant from the arbitration rules and compare.
    task automatic model_eval();
        int g;
        int cnt;
        logic [N-1:0] er;
        g = -1;
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(cur_v[i]);
        for (int off = 0; off < N - 1; off++) begin
            int i;
            i = ((m_ptr - 1 + off) % (N - 1)) + 1;
            if (g < 0 && cur_v[i] && m_wait[i] == MW) g = i;
        end
        if (g < 0 && cur_v[0]) g = 0;
        if (g < 0) begin
            for (int off = 0; off < N - 1; off++) begin
                int i;
                i = ((m_ptr - 1 + off) % (N - 1)) + 1;
                if (g < 0 && cur_v[i]) g = i;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("ready", 64'(req_ready), 64'(er));
        chk("stall", 64'(stall), 64'(cur_v[0] && g != 0));
        for (int i = 1; i < N; i++) begin
            if (!cur_v[i] || g == i) m_wait[i] = 0;
            else if (m_wait[i] < MW) m_wait[i]++;
        end
        if (g >= 1) m_ptr = (g == N - 1) ? 1 : g + 1;
        if (g >= 0) begin
            wb_req_t e;
            e.waddr = cur_addr[g];
            e.wdata = cur_data[g];
            exp_wr_q.push_back(e);
            granted[g] = 1'b1;
        end
        if (rec_en) rec_q.push_back(g);
        exp_cont_q.push_back(cnt >= 2);
        if (cnt >= 2 && m_perf != 32'hFFFF_FFFF) m_perf++;
    endtask

    task automatic step();
        begin_cycle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_reset = 1'b1;
        model_reset();
        drive_bus();
        #1;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_contention", 64'(contention), 64'd0);
        chk("rst_perf", 64'(perf_cnt), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_reset = 1'b0;
        step();
    endtask

    task automatic chk_seq(input string nm, input int exp[]);
        chk({nm, "_len"}, 64'(rec_q.size() >= exp.size()), 64'd1);
        for (int k = 0; k < exp.size() && k < rec_q.size(); k++) begin
            chk(nm, 64'(rec_q[k]), 64'(exp[k]));
        end
    endtask

    task automatic set_prob(input int p0, input int p1, input int p2);
        prob[0] = p0;
        prob[1] = p1;
        prob[2] = p2;
    endtask

    // Monitor: registered outputs sampled 2 time units after the clock edge.
    always begin
        @(posedge clk);
        #2;
        if (!in_reset) begin
            bit exp_we;
            exp_we = (exp_wr_q.size() != 0);
            chk("we_o", 64'(we), 64'(exp_we));
            if (exp_we) begin
                wb_req_t e;
                e = exp_wr_q.pop_front();
                if (we) begin
                    chk("waddr_o", 64'(waddr), 64'(e.waddr));
                    chk("wdata_o", 64'(wdata), 64'(e.wdata));
                end
                m_last_addr = e.waddr;
                m_last_data = e.wdata;
            end else begin
                chk("hold_waddr", 64'(waddr), 64'(m_last_addr));
                chk("hold_wdata", 64'(wdata), 64'(m_last_data));
            end
            if (exp_cont_q.size() != 0) begin
                bit c;
                c = exp_cont_q.pop_front();
                chk("contention_o", 64'(contention), 64'(c));
            end
            chk("perf_cnt_o", 64'(perf_cnt), PERF ? 64'(m_perf) : 64'd0);
        end
    end

    initial begin
        set_prob(0, 0, 0);
        model_reset();
        drive_bus();
        do_reset();

        // Two requesters always valid, req0 idle: alternation from rr_ptr=1 and perf count.
        set_prob(0, 100, 100);
        rec_q.delete();
        rec_en = 1'b1;
        do_reset();
        repeat (9) cycle();
        rec_en = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_perf10", 64'(perf_cnt), PERF ? 64'd10 : 64'd0);
        chk("t3_contention", 64'(contention), 64'd1);
        chk_seq("t3_alt", '{1, 2, 1, 2, 1, 2});
        step();

        // req0 and req1 always valid: req1 breaks through every fifth cycle.
        set_prob(100, 100, 0);
        rec_q.delete();
        rec_en = 1'b1;
        do_reset();
        repeat (9) cycle();
        rec_en = 1'b0;
        chk_seq("t4_aging", '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1});

        // Move rr_ptr to 2, then starve req1 and req2 together.
        set_prob(0, 100, 0);
        do_reset();
        set_prob(100, 100, 100);
        rec_q.delete();
        rec_en = 1'b1;
        repeat (6) cycle();
        rec_en = 1'b0;
        chk_seq("t5_starve", '{0, 0, 0, 0, 2, 1});

        // Reset while grants are flowing.
        do_reset();

        // Single in-order write.
        set_prob(0, 0, 0);
        @(posedge clk);
        #1;
        begin_cycle();
        cur_v[0] = 1'b1;
        cur_addr[0] = 6'd5;
        cur_data[0] = 32'hDEAD_BEEF;
        drive_bus();
        @(negedge clk);
        model_eval();
        chk("t2_ready", 64'(req_ready), 64'b001);
        @(posedge clk);
        #1;
        chk("t2_we", 64'(we), 64'd1);
        chk("t2_waddr", 64'(waddr), 64'd5);
        chk("t2_wdata", 64'(wdata), 64'hDEAD_BEEF);
        step();

        // Randomised traffic with a mid-run reset.
        for (int blk = 0; blk < 12; blk++) begin
            set_prob($urandom_range(100), $urandom_range(100), $urandom_range(100));
            if (blk == 6) do_reset();
            repeat (50) cycle();
        end

        set_prob(0, 0, 0);
        repeat (10) cycle();
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
